// File: rtl/pe_array_core_if.sv
// Stream bundle between the fetchers, the PE array core and the output writer.
// The input word carries the flush bit, the shared feature vector and every PE's filter.
interface pe_array_core_if #(
    parameter int NUM_PES     = 4,
    parameter int VEC_SIZE    = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 32
);
    localparam int IW = 1 + VEC_SIZE*DATA_WIDTH + NUM_PES*VEC_SIZE*DATA_WIDTH;
    localparam int OW = NUM_PES*ACCUM_WIDTH;

    logic          ivalid;
    logic          iready;
    logic [IW-1:0] idata;
    logic          ovalid;
    logic          oready;
    logic [OW-1:0] odata;

    modport master (
        output ivalid, idata, oready,
        input  iready, ovalid, odata
    );

    modport slave (
        input  ivalid, idata, oready,
        output iready, ovalid, odata
    );
endinterface

// File: rtl/pe_array_core.sv
// Fixed-latency array of dot-product PEs sharing one broadcast feature vector,
// each folding its result into a private wrapping accumulator.
module pe_array_core #(
    parameter int NUM_PES          = 4,
    parameter int VEC_SIZE         = 4,
    parameter int DATA_WIDTH       = 8,
    parameter int ACCUM_WIDTH      = 32,
    parameter int TOTAL_LATENCY    = 4,
    parameter int NUM_FLUSH_CYCLES = 1
) (
    input  logic           clock,
    input  logic           resetn,
    pe_array_core_if.slave io
);
    localparam int IW    = 1 + VEC_SIZE*DATA_WIDTH + NUM_PES*VEC_SIZE*DATA_WIDTH;
    localparam int OW    = NUM_PES*ACCUM_WIDTH;
    localparam int PW    = 2*DATA_WIDTH;
    localparam int SW    = 2*DATA_WIDTH + $clog2(VEC_SIZE) + 1;
    localparam int EXTRA = (TOTAL_LATENCY > 4) ? TOTAL_LATENCY - 4 : 0;
    localparam int FOFS  = 1 + VEC_SIZE*DATA_WIDTH;

    // The warm-up word count is a host-side contract only.
    localparam int unused_num_flush = NUM_FLUSH_CYCLES;
    logic unused_oready;
    assign unused_oready = io.oready;

    assign io.iready = resetn;

    // S1: input register
    logic          s1_valid_q, s1_valid_d;
    logic [IW-1:0] s1_word_q,  s1_word_d;

    always_comb begin
        s1_valid_d = io.ivalid;
        s1_word_d  = s1_word_q;
        if (io.ivalid) s1_word_d = io.idata;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_word_q  <= s1_word_d;
        end
    end

    logic                         s1_flush;
    logic signed [DATA_WIDTH-1:0] feat [VEC_SIZE];
    logic signed [DATA_WIDTH-1:0] filt [NUM_PES][VEC_SIZE];

    assign s1_flush = s1_word_q[0];

    for (genvar j = 0; j < VEC_SIZE; j++) begin : g_feat
        assign feat[j] = s1_word_q[1 + j*DATA_WIDTH +: DATA_WIDTH];
        for (genvar p = 0; p < NUM_PES; p++) begin : g_filt
            assign filt[p][j] = s1_word_q[FOFS + (p*VEC_SIZE + j)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // S2: signed products
    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_flush_q, s2_flush_d;
    logic signed [PW-1:0] prod_q [NUM_PES][VEC_SIZE];
    logic signed [PW-1:0] prod_d [NUM_PES][VEC_SIZE];

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_flush_d = s1_flush;
        for (int p = 0; p < NUM_PES; p++) begin
            for (int j = 0; j < VEC_SIZE; j++) begin
                prod_d[p][j] = PW'(feat[j]) * PW'(filt[p][j]);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s2_valid_q <= 1'b0;
            s2_flush_q <= 1'b0;
            for (int p = 0; p < NUM_PES; p++) begin
                for (int j = 0; j < VEC_SIZE; j++) begin
                    prod_q[p][j] <= '0;
                end
            end
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_flush_q <= s2_flush_d;
            prod_q     <= prod_d;
        end
    end

    // Per-PE reduction; SW carries one spare bit so the sum is exact.
    logic signed [SW-1:0] dot_d [NUM_PES];

    always_comb begin
        for (int p = 0; p < NUM_PES; p++) begin
            dot_d[p] = '0;
            for (int j = 0; j < VEC_SIZE; j++) begin
                dot_d[p] = dot_d[p] + SW'(prod_q[p][j]);
            end
        end
    end

    logic                 s3_valid;
    logic                 s3_flush;
    logic signed [SW-1:0] dot_s [NUM_PES];

    // With only three stages the reduction folds into the accumulate cycle.
    if (TOTAL_LATENCY >= 4) begin : g_s3
        logic                 s3_valid_q;
        logic                 s3_flush_q;
        logic signed [SW-1:0] dot_q [NUM_PES];

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                s3_valid_q <= 1'b0;
                s3_flush_q <= 1'b0;
                for (int p = 0; p < NUM_PES; p++) dot_q[p] <= '0;
            end else begin
                s3_valid_q <= s2_valid_q;
                s3_flush_q <= s2_flush_q;
                dot_q      <= dot_d;
            end
        end

        assign s3_valid = s3_valid_q;
        assign s3_flush = s3_flush_q;
        assign dot_s    = dot_q;
    end else begin : g_no_s3
        assign s3_valid = s2_valid_q;
        assign s3_flush = s2_flush_q;
        assign dot_s    = dot_d;
    end

    // S4: accumulate; flush replaces rather than adds, so the flushing word counts.
    logic          s4_valid_q, s4_valid_d;
    logic [OW-1:0] acc_q,      acc_d;

    always_comb begin
        s4_valid_d = s3_valid;
        acc_d      = acc_q;
        if (s3_valid) begin
            for (int p = 0; p < NUM_PES; p++) begin
                if (s3_flush) begin
                    acc_d[p*ACCUM_WIDTH +: ACCUM_WIDTH] = ACCUM_WIDTH'(dot_s[p]);
                end else begin
                    acc_d[p*ACCUM_WIDTH +: ACCUM_WIDTH] =
                        acc_q[p*ACCUM_WIDTH +: ACCUM_WIDTH] + ACCUM_WIDTH'(dot_s[p]);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s4_valid_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            s4_valid_q <= s4_valid_d;
            acc_q      <= acc_d;
        end
    end

    // Tail delay stages only load on valid so odata keeps the last result.
    if (EXTRA > 0) begin : g_tail
        logic          dly_valid_q [EXTRA];
        logic          dly_valid_d [EXTRA];
        logic [OW-1:0] dly_data_q  [EXTRA];
        logic [OW-1:0] dly_data_d  [EXTRA];

        always_comb begin
            dly_valid_d[0] = s4_valid_q;
            dly_data_d[0]  = dly_data_q[0];
            if (s4_valid_q) dly_data_d[0] = acc_q;
            for (int k = 1; k < EXTRA; k++) begin
                dly_valid_d[k] = dly_valid_q[k-1];
                dly_data_d[k]  = dly_data_q[k];
                if (dly_valid_q[k-1]) dly_data_d[k] = dly_data_q[k-1];
            end
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                for (int k = 0; k < EXTRA; k++) begin
                    dly_valid_q[k] <= 1'b0;
                    dly_data_q[k]  <= '0;
                end
            end else begin
                dly_valid_q <= dly_valid_d;
                dly_data_q  <= dly_data_d;
            end
        end

        assign io.ovalid = dly_valid_q[EXTRA-1];
        assign io.odata  = dly_data_q[EXTRA-1];
    end else begin : g_no_tail
        assign io.ovalid = s4_valid_q;
        assign io.odata  = acc_q;
    end
endmodule

// File: tb/tb_pe_array_core.sv
// Scoreboard bench for pe_array_core: driver updates a reference model and queues
// expected words with their due cycle; a negedge monitor pops and compares.
module tb_pe_array_core;
    localparam int NP  = 4;
    localparam int VEC = 4;
    localparam int DW  = 8;
    localparam int AW  = 32;
    localparam int L   = 4;
    localparam int NFC = 1;
    localparam int IW  = 1 + VEC*DW + NP*VEC*DW;
    localparam int OW  = NP*AW;

    typedef struct {
        int unsigned   cyc;
        logic [OW-1:0] data;
    } exp_t;

    logic clock;
    logic resetn;

    pe_array_core_if #(.NUM_PES(NP), .VEC_SIZE(VEC), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW)) bus ();

    pe_array_core #(
        .NUM_PES(NP), .VEC_SIZE(VEC), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW),
        .TOTAL_LATENCY(L), .NUM_FLUSH_CYCLES(NFC)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .io    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc++;

    exp_t          sb[$];
    logic [AW-1:0] m_acc [NP];
    int            n_vec = 0;
    int            n_err = 0;
    int            feat [VEC];
    int            filt [NP][VEC];

    // Reference model: plain integer dot products and modulo-2^AW accumulation.
    task automatic send(input bit v, input bit fl, input int f[VEC], input int g[NP][VEC]);
        logic [IW-1:0] w;
        logic [OW-1:0] ed;
        int            dot;
        exp_t          e;
        w    = '0;
        w[0] = fl;
        for (int j = 0; j < VEC; j++) w[1 + j*DW +: DW] = DW'(f[j]);
        for (int p = 0; p < NP; p++)
            for (int j = 0; j < VEC; j++)
                w[1 + VEC*DW + (p*VEC + j)*DW +: DW] = DW'(g[p][j]);
        @(posedge clock);
        #1;
        bus.ivalid = v;
        bus.idata  = w;
        bus.oready = 1'($urandom_range(0, 1));
        if (v) begin
            for (int p = 0; p < NP; p++) begin
                dot = 0;
                for (int j = 0; j < VEC; j++) dot += f[j] * g[p][j];
                m_acc[p] = fl ? AW'(dot) : m_acc[p] + AW'(dot);
                ed[p*AW +: AW] = m_acc[p];
            end
            e.cyc  = cyc + L;
            e.data = ed;
            sb.push_back(e);
        end
    endtask

    task automatic fill(input int fv, input int gv);
        for (int j = 0; j < VEC; j++) begin
            feat[j] = fv;
            for (int p = 0; p < NP; p++) filt[p][j] = gv;
        end
    endtask

    task automatic fill_random();
        for (int j = 0; j < VEC; j++) begin
            feat[j] = int'($urandom_range(0, 255)) - 128;
            for (int p = 0; p < NP; p++) filt[p][j] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic warm_up();
        fill(0, 0);
        send(1'b1, 1'b1, feat, filt);
        for (int i = 0; i < NFC; i++) send(1'b1, 1'b0, feat, filt);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        bus.ivalid = 1'b0;
        bus.idata  = '0;
        #2;
        resetn = 1'b0;
        sb.delete();
        for (int p = 0; p < NP; p++) m_acc[p] = '0;
        repeat (3) @(posedge clock);
        #3;
        resetn = 1'b1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!resetn) begin
            n_vec++;
            if (bus.ovalid !== 1'b0 || bus.odata !== '0 || bus.iready !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state: got ovalid=%0b iready=%0b odata=%h, required 0 0 0",
                         bus.ovalid, bus.iready, bus.odata);
            end
        end else begin
            if (bus.iready !== 1'b1) begin
                n_err++;
                $display("FAIL iready: got %0b required 1 at cycle %0d", bus.iready, cyc);
            end
            if (bus.ovalid === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ovalid: got ovalid=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || bus.odata !== e.data) begin
                        n_err++;
                        $display("FAIL odata: got %h at cycle %0d, required %h at cycle %0d",
                                 bus.odata, cyc, e.data, e.cyc);
                    end
                end
            end else if (bus.ovalid !== 1'b0) begin
                n_vec++;
                n_err++;
                $display("FAIL ovalid_x: got %b required 0/1 at cycle %0d", bus.ovalid, cyc);
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                n_vec++;
                n_err++;
                e = sb.pop_front();
                $display("FAIL missing_ovalid: got ovalid=0 at cycle %0d, required word %h due cycle %0d",
                         cyc, e.data, e.cyc);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, %0d expected words outstanding", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b1;
        bus.ivalid = 1'b0;
        bus.idata  = '0;
        bus.oready = 1'b0;
        for (int p = 0; p < NP; p++) m_acc[p] = '0;
        #1;
        resetn = 1'b0;
        repeat (4) @(posedge clock);
        #3;
        resetn = 1'b1;

        warm_up();

        // Flush / accumulate / re-flush: 10, 20, 10 per PE.
        fill(1, 1);
        for (int j = 0; j < VEC; j++) feat[j] = j + 1;
        send(1'b1, 1'b1, feat, filt);
        send(1'b1, 1'b0, feat, filt);
        send(1'b1, 1'b1, feat, filt);

        // Signed extremes: PE0 = 65536, PE1 = -65024.
        fill(-128, 0);
        for (int j = 0; j < VEC; j++) begin
            filt[0][j] = -128;
            filt[1][j] = 127;
            filt[3][j] = int'($urandom_range(0, 255)) - 128;
        end
        send(1'b1, 1'b1, feat, filt);

        // Bubbles: invalid words carry flush and data that must be ignored -> 4, 8.
        fill(0, 0);
        send(1'b1, 1'b1, feat, filt);
        fill(1, 1);
        send(1'b1, 1'b0, feat, filt);
        fill(7, -3);
        send(1'b0, 1'b1, feat, filt);
        send(1'b0, 1'b1, feat, filt);
        fill(1, 1);
        send(1'b1, 1'b0, feat, filt);

        // Wrap: 2^15 words of +65536 reach 0x80000000, then keep wrapping.
        fill(-128, -128);
        send(1'b1, 1'b1, feat, filt);
        for (int i = 1; i < 32768 + 3; i++) send(1'b1, 1'b0, feat, filt);

        // Random traffic with an asynchronous mid-stream reset.
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                do_reset();
                fill_random();
                send(1'b1, 1'b0, feat, filt);
                warm_up();
            end
            fill_random();
            send($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 10, feat, filt);
        end

        fill(0, 0);
        for (int i = 0; i < L + 3; i++) send(1'b0, 1'b0, feat, filt);
        @(negedge clock);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d outstanding expected words, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
